// File: rtl/softmax_pkg.sv
// Shared constants and elaboration-time helpers for the streaming softmax head.
package softmax_pkg;

    localparam int E_W = 16;
    localparam logic [15:0] LOG2E = 16'd47274;

    typedef logic [1:0] state_t;
    localparam state_t S_LOAD = 2'd0;
    localparam state_t S_EXP  = 2'd1;
    localparam state_t S_DIV  = 2'd2;
    localparam state_t S_OUT  = 2'd3;

    function automatic int sum_width(input int c);
        return E_W + $clog2(c + 1);
    endfunction

    // round(32768 * 2^(-k / 2^lut_bits)); only ever evaluated at elaboration
    function automatic logic [E_W-1:0] exp2_lut(input int k, input int lut_bits);
        real r;
        r = 32768.0 * (2.0 ** (-(real'(k)) / real'(2 ** lut_bits)));
        return E_W'($rtoi(r + 0.5));
    endfunction

endpackage

// File: rtl/softmax_stream_div.sv
// Restoring divider: quo = min(floor(num * 2^OUT_WIDTH / den), 2^OUT_WIDTH - 1), 1 bit/cycle.
module softmax_div
    import softmax_pkg::*;
#(
    parameter int SUM_W     = 20,
    parameter int OUT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [E_W-1:0]       num,
    input  logic [SUM_W-1:0]     den,
    output logic                 done,
    output logic [OUT_WIDTH-1:0] quo
);
    localparam int CNT_W = $clog2(OUT_WIDTH + 2);

    logic [SUM_W-1:0]   rem;
    logic [OUT_WIDTH:0] q_acc;
    logic [CNT_W-1:0]   cnt;
    logic               busy;
    logic [SUM_W-1:0]   rem_src;
    logic               bit_in;
    logic [SUM_W:0]     trial;
    logic               fits;
    logic [SUM_W-1:0]   rem_next;

    // the first step consumes num itself (quotient bit OUT_WIDTH), later steps shift in zeros
    always_comb begin
        rem_src  = start ? SUM_W'(num >> 1) : rem;
        bit_in   = start ? num[0] : 1'b0;
        trial    = {rem_src, bit_in};
        fits     = trial >= {1'b0, den};
        rem_next = fits ? SUM_W'(trial - {1'b0, den}) : trial[SUM_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem   <= '0;
            q_acc <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem   <= rem_next;
                q_acc <= {{OUT_WIDTH{1'b0}}, fits};
                cnt   <= CNT_W'(OUT_WIDTH);
                busy  <= 1'b1;
            end else if (busy) begin
                rem   <= rem_next;
                q_acc <= {q_acc[OUT_WIDTH-1:0], fits};
                cnt   <= cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign quo = q_acc[OUT_WIDTH] ? {OUT_WIDTH{1'b1}} : q_acc[OUT_WIDTH-1:0];

endmodule

// File: rtl/softmax_stream.sv
// Frame-based fixed-point softmax: load C logits, base-2 exp with max subtraction, divide, stream out.
module softmax_stream
    import softmax_pkg::*;
#(
    parameter int C          = 10,
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int OUT_WIDTH  = 16,
    parameter int LUT_BITS   = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    output logic                  in_ready,
    output logic [OUT_WIDTH-1:0]  pxl_out,
    output logic                  valid_out,
    input  logic                  out_ready,
    output logic                  last_out
);
    localparam int BUF_W  = (DATA_WIDTH > E_W) ? DATA_WIDTH : E_W;
    localparam int SUM_W  = sum_width(C);
    localparam int IDX_W  = (C > 1) ? $clog2(C) : 1;
    localparam int D_W    = DATA_WIDTH + 1;
    localparam int T_W    = D_W + 16;
    localparam int SHIFT  = FRAC_BITS + 15;
    localparam int T_HI_W = T_W - (SHIFT - LUT_BITS);
    localparam int N_W    = T_HI_W - LUT_BITS;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(C - 1);

    state_t                        state;
    logic [IDX_W-1:0]              idx;
    logic [BUF_W-1:0]              buf_mem [C];
    logic signed [DATA_WIDTH-1:0]  max_q;
    logic [SUM_W-1:0]              sum;
    logic                          div_started;
    logic                          div_done;
    logic [OUT_WIDTH-1:0]          div_quo;
    logic [E_W-1:0]                lut [2**LUT_BITS];

    for (genvar k = 0; k < 2**LUT_BITS; k++) begin : g_lut
        assign lut[k] = exp2_lut(k, LUT_BITS);
    end

    logic [DATA_WIDTH-1:0] x_cur;
    logic [D_W-1:0]        d;
    logic [T_HI_W-1:0]     t_hi;
    logic [N_W-1:0]        n;
    logic [LUT_BITS-1:0]   f;
    logic [E_W-1:0]        e;
    logic                  buf_we;
    logic [BUF_W-1:0]      buf_wdata;

    // t_hi keeps only the integer part and the LUT_BITS fraction bits of (max - x) * log2(e)
    always_comb begin
        x_cur     = buf_mem[idx][DATA_WIDTH-1:0];
        d         = {max_q[DATA_WIDTH-1], max_q} - {x_cur[DATA_WIDTH-1], x_cur};
        t_hi      = T_HI_W'((T_W'(d) * T_W'(LOG2E)) >> (SHIFT - LUT_BITS));
        n         = t_hi[T_HI_W-1:LUT_BITS];
        f         = t_hi[LUT_BITS-1:0];
        e         = (n >= N_W'(E_W)) ? '0 : E_W'(lut[f] >> n);
        buf_we    = ((state == S_LOAD) && valid_in) || (state == S_EXP);
        buf_wdata = (state == S_EXP) ? BUF_W'(e) : BUF_W'(pxl_in);
    end

    always_ff @(posedge clk) begin
        if (buf_we) buf_mem[idx] <= buf_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_LOAD;
            idx         <= '0;
            sum         <= '0;
            max_q       <= '0;
            div_started <= 1'b0;
            pxl_out     <= '0;
            valid_out   <= 1'b0;
            last_out    <= 1'b0;
        end else begin
            case (state)
                S_LOAD: if (valid_in) begin
                    if (idx == '0 || $signed(pxl_in) > max_q) max_q <= $signed(pxl_in);
                    if (idx == LAST_IDX) begin
                        idx   <= '0;
                        state <= S_EXP;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_EXP: begin
                    sum <= sum + SUM_W'(e);
                    if (idx == LAST_IDX) begin
                        idx   <= '0;
                        state <= S_DIV;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_DIV: begin
                    div_started <= 1'b1;
                    if (div_done) begin
                        pxl_out   <= div_quo;
                        valid_out <= 1'b1;
                        last_out  <= (idx == LAST_IDX);
                        state     <= S_OUT;
                    end
                end
                default: if (out_ready) begin
                    valid_out   <= 1'b0;
                    last_out    <= 1'b0;
                    div_started <= 1'b0;
                    if (idx == LAST_IDX) begin
                        idx   <= '0;
                        sum   <= '0;
                        state <= S_LOAD;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= S_DIV;
                    end
                end
            endcase
        end
    end

    assign in_ready = (state == S_LOAD);

    softmax_div #(
        .SUM_W     (SUM_W),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_div (
        .clk   (clk),
        .reset (reset),
        .start ((state == S_DIV) && !div_started),
        .num   (buf_mem[idx][E_W-1:0]),
        .den   (sum),
        .done  (div_done),
        .quo   (div_quo)
    );

endmodule

// File: tb/tb_softmax_stream.sv
// Randomized self-checking bench for softmax_stream against a plain-arithmetic softmax reference.
module tb_softmax_stream;
    localparam int C  = 4;
    localparam int OW = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in, in_ready, valid_out, out_ready, last_out;
    logic [15:0] pxl_in, pxl_out;
    logic        v1_in, r1_in, vo1, or1, lo1;
    logic [15:0] p1_in, po1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    softmax_stream #(.C(C), .DATA_WIDTH(16), .FRAC_BITS(8), .OUT_WIDTH(OW), .LUT_BITS(6)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .pxl_in(pxl_in), .in_ready(in_ready),
        .pxl_out(pxl_out), .valid_out(valid_out), .out_ready(out_ready), .last_out(last_out));

    softmax_stream #(.C(1), .DATA_WIDTH(16), .FRAC_BITS(8), .OUT_WIDTH(OW), .LUT_BITS(6)) dut1 (
        .clk(clk), .reset(reset), .valid_in(v1_in), .pxl_in(p1_in), .in_ready(r1_in),
        .pxl_out(po1), .valid_out(vo1), .out_ready(or1), .last_out(lo1));

    task automatic chk(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int lut_ref(input int k);
        return int'($floor(32768.0 * (2.0 ** (-(real'(k)) / 64.0)) + 0.5));
    endfunction

    // softmax as defined: exp via 2^-(n+f) with truncated f, normalised by the integer sum
    function automatic void model(input int lg[$], output int q[$]);
        int mx;
        longint e[$];
        longint s;
        mx = lg[0];
        foreach (lg[i]) if (lg[i] > mx) mx = lg[i];
        s = 0;
        q = {};
        foreach (lg[i]) begin
            longint dd, t, nn;
            int ff;
            dd = longint'(mx - lg[i]);
            t  = dd * 47274;
            nn = t / (longint'(1) << 23);
            ff = int'((t / (longint'(1) << 17)) % 64);
            e.push_back(nn >= 16 ? 0 : (lut_ref(ff) >> nn));
            s += e[i];
        end
        foreach (e[i]) begin
            longint v;
            v = (e[i] * 65536) / s;
            q.push_back(v > 65535 ? 65535 : int'(v));
        end
    endfunction

    task automatic send_frame(input int lg[$], input bit gaps);
        int guard;
        foreach (lg[i]) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            valid_in = 1'b1;
            pxl_in   = 16'(lg[i]);
            guard    = 0;
            while (!in_ready && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            if (!in_ready) chk("in_ready_timeout", 0, 1);
            @(negedge clk);
            valid_in = 1'b0;
        end
    endtask

    task automatic recv_frame(input int q[$], input bit stall, input bit noise, input int lat);
        int cnt;
        foreach (q[i]) begin
            cnt = 0;
            while (!valid_out && cnt < 200) begin
                if (noise) begin
                    valid_in = 1'b1;
                    pxl_in   = 16'($urandom);
                end
                @(negedge clk);
                cnt++;
            end
            if (!valid_out) begin
                chk("valid_timeout", 0, 1);
                valid_in = 1'b0;
                return;
            end
            if (i == 0 && lat >= 0) chk("latency", cnt, lat);
            chk("in_ready_busy", in_ready, 0);
            if (stall) repeat (5) begin
                chk("stall_valid", valid_out, 1);
                chk("stall_pxl", pxl_out, q[i]);
                chk("stall_last", last_out, (i == q.size() - 1));
                if (noise) begin
                    valid_in = 1'b1;
                    pxl_in   = 16'($urandom);
                end
                @(negedge clk);
            end
            chk("pxl", pxl_out, q[i]);
            chk("last", last_out, (i == q.size() - 1));
            valid_in  = 1'b0;
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
        chk("in_ready_after", in_ready, 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_valid"}, valid_out, 0);
        chk({tag, "_pxl"}, pxl_out, 0);
        chk({tag, "_last"}, last_out, 0);
    endtask

    initial begin
        int lg[$];
        int q[$];
        int cnt;

        reset = 1'b1; valid_in = 1'b0; pxl_in = '0; out_ready = 1'b0;
        v1_in = 1'b0; p1_in = '0; or1 = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", in_ready, 1);
        check_idle_outputs("post_reset");

        // all-equal logits, uniform distribution
        lg = '{0, 0, 0, 0};
        model(lg, q);
        send_frame(lg, 0);
        recv_frame(q, 0, 0, C + OW + 2);

        // one dominant logit; first-output latency from the last beat
        lg = '{512, 0, 0, 0};
        model(lg, q);
        send_frame(lg, 0);
        recv_frame(q, 0, 0, C + OW + 2);

        // exponent underflow: n >= 16 gives e = 0
        lg = '{0, -5120, -5120, -5120};
        model(lg, q);
        send_frame(lg, 1);
        recv_frame(q, 0, 0, -1);

        // random frames, plain then stalled with input noise during output
        repeat (6) begin
            lg = {};
            repeat (C) lg.push_back(int'($urandom_range(0, 4095)) - 2048);
            model(lg, q);
            send_frame(lg, 1);
            recv_frame(q, 0, 0, -1);
            send_frame(lg, 1);
            recv_frame(q, 1, 1, -1);
        end

        // reset mid-load discards the partial frame
        valid_in = 1'b1; pxl_in = 16'(512);
        @(negedge clk);
        pxl_in = 16'(-1000);
        @(negedge clk);
        valid_in = 1'b0;
        reset = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check_idle_outputs("mid_reset");
        end
        reset = 1'b0;
        @(negedge clk);
        chk("mid_reset_in_ready", in_ready, 1);
        lg = '{0, 0, 0, 0};
        model(lg, q);
        send_frame(lg, 0);
        recv_frame(q, 0, 0, C + OW + 2);

        // reset while an output is pending
        lg = '{300, -200, 100, 0};
        send_frame(lg, 0);
        cnt = 0;
        while (!valid_out && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        chk("pending_valid", valid_out, 1);
        reset = 1'b1;
        @(negedge clk);
        check_idle_outputs("pending_reset");
        reset = 1'b0;
        @(negedge clk);
        chk("pending_in_ready", in_ready, 1);
        lg = '{0, 0, 0, 0};
        model(lg, q);
        send_frame(lg, 0);
        recv_frame(q, 0, 0, -1);

        // single-class instance always saturates
        repeat (2) begin
            v1_in = 1'b1;
            p1_in = 16'($urandom);
            @(negedge clk);
            v1_in = 1'b0;
            cnt = 0;
            while (!vo1 && cnt < 200) begin
                @(negedge clk);
                cnt++;
            end
            chk("c1_valid", vo1, 1);
            chk("c1_pxl", po1, 65535);
            chk("c1_last", lo1, 1);
            or1 = 1'b1;
            @(negedge clk);
            or1 = 1'b0;
            chk("c1_in_ready", r1_in, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
